// File: rtl/uart_debug_controller.sv
// Debug sequencer between a 32-bit UART and the MIPS core: program load, single-step,
// free-run and a PC/register/data-memory dump to the host.
module uart_debug_controller #(
  parameter int          NB_DATA      = 32,
  parameter int          NB_BYTE      = 8,
  parameter int          NB_REG_ADDR  = 5,
  parameter int          NB_IMEM_ADDR = 8,
  parameter int          NB_DMEM_ADDR = 8,
  parameter int          N_DMEM_DUMP  = 16,
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter logic [7:0]  CMD_LOAD     = 8'h4C,
  parameter logic [7:0]  CMD_STEP     = 8'h53,
  parameter logic [7:0]  CMD_RUN      = 8'h52
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_BYTE-1:0]      i_rx_data,
  input  logic                    i_rx_done_pulse,
  input  logic                    i_tx_done_32b_pulse,
  output logic [NB_DATA-1:0]      o_tx_data,
  output logic                    o_tx_start_32b,
  output logic                    o_cpu_enable,
  output logic                    o_cpu_reset,
  input  logic                    i_cpu_halt,
  input  logic [NB_DATA-1:0]      i_pc,
  output logic                    o_imem_wr_en,
  output logic [NB_IMEM_ADDR-1:0] o_imem_wr_addr,
  output logic [NB_DATA-1:0]      o_imem_wr_data,
  output logic [NB_REG_ADDR-1:0]  o_reg_rd_addr,
  input  logic [NB_DATA-1:0]      i_reg_rd_data,
  output logic [NB_DMEM_ADDR-1:0] o_dmem_rd_addr,
  input  logic [NB_DATA-1:0]      i_dmem_rd_data
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] LOAD_BYTE  = 4'd1;
  localparam logic [3:0] LOAD_WRITE = 4'd2;
  localparam logic [3:0] LOAD_ACK   = 4'd3;
  localparam logic [3:0] STEP       = 4'd4;
  localparam logic [3:0] RUN        = 4'd5;
  localparam logic [3:0] DUMP_ADDR  = 4'd6;
  localparam logic [3:0] DUMP_LATCH = 4'd7;
  localparam logic [3:0] DUMP_SEND  = 4'd8;
  localparam logic [3:0] DUMP_WAIT  = 4'd9;

  localparam int N_REGS  = 1 << NB_REG_ADDR;
  localparam int N_WORDS = 1 + N_REGS + N_DMEM_DUMP;
  localparam int IDX_W   = $clog2(N_WORDS + 1);

  localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0]        IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]        IDX_REGS  = IDX_W'(N_REGS);
  localparam logic [NB_IMEM_ADDR-1:0] IMEM_LAST = '1;
  localparam logic [NB_IMEM_ADDR-1:0] IMEM_ONE  = NB_IMEM_ADDR'(1);
  localparam logic [NB_IMEM_ADDR:0]   WW_ONE    = (NB_IMEM_ADDR+1)'(1);

  logic [3:0]              state;
  logic [1:0]              byte_cnt;
  logic [NB_DATA-1:0]      word;
  logic [NB_IMEM_ADDR:0]   words_written;
  logic [IDX_W-1:0]        idx;

  // Dump word index 0 is the PC, 1..N_REGS the registers, the rest the dmem window.
  function automatic logic [NB_REG_ADDR-1:0] reg_addr_of(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] t;
    t = i - IDX_ONE;
    return (i >= IDX_ONE && i <= IDX_REGS) ? t[NB_REG_ADDR-1:0] : '0;
  endfunction

  function automatic logic [NB_DMEM_ADDR-1:0] dmem_addr_of(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] t;
    t = i - IDX_REGS - IDX_ONE;
    return (i > IDX_REGS) ? NB_DMEM_ADDR'(t) : '0;
  endfunction

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      word           <= '0;
      words_written  <= '0;
      idx            <= '0;
      o_tx_data      <= '0;
      o_tx_start_32b <= 1'b0;
      o_cpu_enable   <= 1'b0;
      o_cpu_reset    <= 1'b0;
      o_imem_wr_en   <= 1'b0;
      o_imem_wr_addr <= '0;
      o_imem_wr_data <= '0;
      o_reg_rd_addr  <= '0;
      o_dmem_rd_addr <= '0;
    end else begin
      o_tx_start_32b <= 1'b0;
      o_cpu_enable   <= 1'b0;
      o_cpu_reset    <= 1'b0;
      o_imem_wr_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rx_done_pulse) begin
            if (i_rx_data == CMD_LOAD) begin
              o_cpu_reset    <= 1'b1;
              o_imem_wr_addr <= '0;
              words_written  <= '0;
              byte_cnt       <= '0;
              state          <= LOAD_BYTE;
            end else if (i_rx_data == CMD_STEP) begin
              o_cpu_enable <= 1'b1;
              state        <= STEP;
            end else if (i_rx_data == CMD_RUN) begin
              o_cpu_enable <= 1'b1;
              state        <= RUN;
            end
          end
        end
        LOAD_BYTE: begin
          if (i_rx_done_pulse) begin
            word     <= {word[NB_DATA-NB_BYTE-1:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              o_imem_wr_en   <= 1'b1;
              o_imem_wr_data <= {word[NB_DATA-NB_BYTE-1:0], i_rx_data};
              state          <= LOAD_WRITE;
            end
          end
        end
        LOAD_WRITE: begin
          words_written <= words_written + WW_ONE;
          // The last address does not wrap: a full memory ends the load like a halt word.
          if (o_imem_wr_data == HALT_INSTR || o_imem_wr_addr == IMEM_LAST) begin
            o_tx_data      <= NB_DATA'(words_written + WW_ONE);
            o_tx_start_32b <= 1'b1;
            state          <= LOAD_ACK;
          end else begin
            o_imem_wr_addr <= o_imem_wr_addr + IMEM_ONE;
            state          <= LOAD_BYTE;
          end
        end
        LOAD_ACK: begin
          if (i_tx_done_32b_pulse) state <= IDLE;
        end
        STEP, RUN: begin
          if (state == RUN && !i_cpu_halt) begin
            o_cpu_enable <= 1'b1;
          end else begin
            idx            <= '0;
            o_reg_rd_addr  <= reg_addr_of('0);
            o_dmem_rd_addr <= dmem_addr_of('0);
            state          <= DUMP_ADDR;
          end
        end
        DUMP_ADDR: state <= DUMP_LATCH;
        DUMP_LATCH: begin
          if (idx == '0)            o_tx_data <= i_pc;
          else if (idx <= IDX_REGS) o_tx_data <= i_reg_rd_data;
          else                      o_tx_data <= i_dmem_rd_data;
          o_tx_start_32b <= 1'b1;
          state          <= DUMP_SEND;
        end
        DUMP_SEND: state <= DUMP_WAIT;
        DUMP_WAIT: begin
          if (i_tx_done_32b_pulse) begin
            if (idx == IDX_LAST) begin
              state <= IDLE;
            end else begin
              idx            <= idx + IDX_ONE;
              o_reg_rd_addr  <= reg_addr_of(idx + IDX_ONE);
              o_dmem_rd_addr <= dmem_addr_of(idx + IDX_ONE);
              state          <= DUMP_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debug_controller.sv
// Directed bench for uart_debug_controller: load, step, run, ignored bytes,
// small-imem load overflow and reset during a dump.
module tb_uart_debug_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;
  logic [31:0] tx_data;
  logic        tx_start, cpu_enable, cpu_reset, imem_wr_en;
  logic [7:0]  imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic [4:0]  reg_rd_addr;
  logic [7:0]  dmem_rd_addr;
  logic [31:0] reg_rd_data = '0;
  logic [31:0] dmem_rd_data = '0;
  logic [31:0] pc = '0;
  logic        cpu_halt;

  // Second instance with a 4-word instruction memory
  logic [7:0]  rx_data2 = '0;
  logic        rx_done2 = 1'b0;
  logic        tx_done2 = 1'b0;
  logic [31:0] tx_data2;
  logic        tx_start2, cpu_enable2, cpu_reset2, imem_wr_en2;
  logic [1:0]  imem_wr_addr2;
  logic [31:0] imem_wr_data2;
  logic [4:0]  reg_rd_addr2;
  logic [7:0]  dmem_rd_addr2;

  uart_debug_controller dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done_pulse(rx_done),
    .i_tx_done_32b_pulse(tx_done), .o_tx_data(tx_data), .o_tx_start_32b(tx_start),
    .o_cpu_enable(cpu_enable), .o_cpu_reset(cpu_reset), .i_cpu_halt(cpu_halt), .i_pc(pc),
    .o_imem_wr_en(imem_wr_en), .o_imem_wr_addr(imem_wr_addr), .o_imem_wr_data(imem_wr_data),
    .o_reg_rd_addr(reg_rd_addr), .i_reg_rd_data(reg_rd_data),
    .o_dmem_rd_addr(dmem_rd_addr), .i_dmem_rd_data(dmem_rd_data)
  );

  uart_debug_controller #(.NB_IMEM_ADDR(2)) dut2 (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data2), .i_rx_done_pulse(rx_done2),
    .i_tx_done_32b_pulse(tx_done2), .o_tx_data(tx_data2), .o_tx_start_32b(tx_start2),
    .o_cpu_enable(cpu_enable2), .o_cpu_reset(cpu_reset2), .i_cpu_halt(1'b0), .i_pc(32'h0),
    .o_imem_wr_en(imem_wr_en2), .o_imem_wr_addr(imem_wr_addr2), .o_imem_wr_data(imem_wr_data2),
    .o_reg_rd_addr(reg_rd_addr2), .i_reg_rd_data(32'h0),
    .o_dmem_rd_addr(dmem_rd_addr2), .i_dmem_rd_data(32'h0)
  );

  int checks = 0;
  int failures = 0;

  int tx_total = 0, en_total = 0, crst_total = 0, wr_total = 0;
  int tx2_total = 0, wr2_total = 0;
  logic [31:0] tx_log [0:511];
  logic [31:0] wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];
  logic [31:0] tx2_log [0:15];
  logic [31:0] wr2_addr_log [0:15];
  logic [31:0] wr2_data_log [0:15];

  logic halt_arm = 1'b0;
  int   en_base = 0;
  int   tx_cnt = 0;

  assign cpu_halt = halt_arm && ((en_total - en_base) >= 10);

  // Register file r[i]=i and data memory dmem[j]=100+j, one-cycle read latency
  always @(posedge clk) begin
    reg_rd_data  <= 32'(reg_rd_addr);
    dmem_rd_data <= 32'd100 + 32'(dmem_rd_addr);
  end

  // Transmitter model: done pulse a few cycles after each start
  always @(negedge clk) begin
    tx_done <= 1'b0;
    if (rst) tx_cnt <= 0;
    else if (tx_start) tx_cnt <= 4;
    else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (tx_start) begin tx_log[tx_total] <= tx_data; tx_total <= tx_total + 1; end
    if (cpu_enable) en_total <= en_total + 1;
    if (cpu_reset) crst_total <= crst_total + 1;
    if (imem_wr_en) begin
      wr_addr_log[wr_total] <= 32'(imem_wr_addr);
      wr_data_log[wr_total] <= imem_wr_data;
      wr_total <= wr_total + 1;
    end
    if (tx_start2) begin tx2_log[tx2_total] <= tx_data2; tx2_total <= tx2_total + 1; end
    if (imem_wr_en2) begin
      wr2_addr_log[wr2_total] <= 32'(imem_wr_addr2);
      wr2_data_log[wr2_total] <= imem_wr_data2;
      wr2_total <= wr2_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte2(input logic [7:0] b);
    @(negedge clk); rx_data2 = b; rx_done2 = 1'b1;
    @(negedge clk); rx_done2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n;
    n = 0;
    while (tx_total < target && n < budget) begin @(negedge clk); n++; end
    check("tx_wait_bound", 32'(tx_total >= target), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_data"}, tx_data, 32'h0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'h0);
    check({tag, "_cpu_en"}, 32'(cpu_enable), 32'h0);
    check({tag, "_cpu_rst"}, 32'(cpu_reset), 32'h0);
    check({tag, "_wr_en"}, 32'(imem_wr_en), 32'h0);
    check({tag, "_wr_addr"}, 32'(imem_wr_addr), 32'h0);
    check({tag, "_wr_data"}, imem_wr_data, 32'h0);
    check({tag, "_reg_addr"}, 32'(reg_rd_addr), 32'h0);
    check({tag, "_dmem_addr"}, 32'(dmem_rd_addr), 32'h0);
  endtask

  task automatic check_dump(input int base, input string tag);
    check({tag, "_pc"}, tx_log[base], 32'h4);
    for (int i = 0; i < 32; i++) check({tag, "_reg"}, tx_log[base + 1 + i], 32'(i));
    for (int j = 0; j < 16; j++) check({tag, "_dmem"}, tx_log[base + 33 + j], 32'(100 + j));
  endtask

  int b_tx, b_en, b_crst, b_wr, d;
  logic [31:0] exp2 [0:3];

  initial begin
    exp2[0] = 32'h01020304; exp2[1] = 32'h05060708;
    exp2[2] = 32'h090A0B0C; exp2[3] = 32'h0D0E0F10;
    pc = 32'h4;

    // Reset state
    idle(3);
    rst = 1'b0;
    idle(1);
    check_outputs_zero("reset");

    // 1. Program load terminated by halt word
    b_tx = tx_total; b_crst = crst_total; b_wr = wr_total;
    send_byte(8'h4C);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    wait_tx(b_tx + 1, 100);
    idle(2);
    check("load_cpu_reset_count", 32'(crst_total - b_crst), 32'd1);
    check("load_write_count", 32'(wr_total - b_wr), 32'd3);
    check("load_w0_addr", wr_addr_log[b_wr], 32'd0);
    check("load_w0_data", wr_data_log[b_wr], 32'hDEADBEEF);
    check("load_w1_addr", wr_addr_log[b_wr + 1], 32'd1);
    check("load_w1_data", wr_data_log[b_wr + 1], 32'h00000001);
    check("load_w2_addr", wr_addr_log[b_wr + 2], 32'd2);
    check("load_w2_data", wr_data_log[b_wr + 2], 32'hFFFFFFFF);
    check("load_ack", tx_log[b_tx], 32'h3);
    idle(10);

    // 2. Single step then dump
    b_tx = tx_total; b_en = en_total;
    send_byte(8'h53);
    wait_tx(b_tx + 49, 2000);
    idle(10);
    check("step_enable_cycles", 32'(en_total - b_en), 32'd1);
    check("step_word_count", 32'(tx_total - b_tx), 32'd49);
    check_dump(b_tx, "step");

    // 3. Free run until halt, then dump
    b_tx = tx_total; en_base = en_total; halt_arm = 1'b1;
    send_byte(8'h52);
    wait_tx(b_tx + 49, 3000);
    idle(10);
    d = en_total - en_base;
    check("run_enable_10_to_11", 32'(d == 10 || d == 11), 32'd1);
    check("run_word_count", 32'(tx_total - b_tx), 32'd49);
    check_dump(b_tx, "run");
    halt_arm = 1'b0;

    // 4. Unknown command byte in IDLE
    b_tx = tx_total; b_en = en_total; b_wr = wr_total; b_crst = crst_total;
    send_byte(8'h41);
    idle(20);
    check("ignore_writes", 32'(wr_total - b_wr), 32'd0);
    check("ignore_enable", 32'(en_total - b_en), 32'd0);
    check("ignore_tx", 32'(tx_total - b_tx), 32'd0);
    check("ignore_cpu_reset", 32'(crst_total - b_crst), 32'd0);

    // 5. Small instruction memory fills after four words; fifth word dropped
    send_byte2(8'h4C);
    for (int i = 1; i <= 20; i++) send_byte2(8'(i));
    idle(5);
    check("small_write_count", 32'(wr2_total), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("small_wr_addr", wr2_addr_log[k], 32'(k));
      check("small_wr_data", wr2_data_log[k], exp2[k]);
    end
    check("small_ack_count", 32'(tx2_total), 32'd1);
    check("small_ack_word", tx2_log[0], 32'h4);
    @(negedge clk); tx_done2 = 1'b1;
    @(negedge clk); tx_done2 = 1'b0;
    idle(10);
    check("small_no_extra_writes", 32'(wr2_total), 32'd4);
    check("small_no_extra_tx", 32'(tx2_total), 32'd1);

    // 6. Reset in the middle of a dump, then a clean step
    b_tx = tx_total;
    send_byte(8'h53);
    wait_tx(b_tx + 20, 1000);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    rst = 1'b0;
    b_tx = tx_total;
    idle(20);
    check("midreset_no_tx", 32'(tx_total - b_tx), 32'd0);
    b_tx = tx_total; b_en = en_total;
    send_byte(8'h53);
    wait_tx(b_tx + 49, 2000);
    idle(10);
    check("restep_enable_cycles", 32'(en_total - b_en), 32'd1);
    check("restep_word_count", 32'(tx_total - b_tx), 32'd49);
    check_dump(b_tx, "restep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
